core_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer for the PISA core. It owns the instruction pointer and the FETCH/DECODE/MEMORY/EXECUTE/WRITEBACK/HALT state. It adds a bus ready handshake with wait states, a bus timeout trap, resume-from-HALT and a retired-instruction counter. It sits between the IFU/CU (decode feedback) and the memory bus; datapath blocks (ALU, RegisterFile) consume its state and strobes.

---
 rtl/core_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_core_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//
// Multi-cycle control sequencer for the PISA core. It owns the instruction
// pointer and walks each instruction through FETCH, DECODE, optional MEMORY,
// EXECUTE and WRITEBACK. Bus accesses use a ready handshake with wait states
// and a bus timeout that traps into HALT. HALT is left through `resume`.
// The block also counts retired instructions.
//
// Ports:
//   clk           in   clock; all state updates on the rising edge
//   rst           in   asynchronous reset, active low
//   enable_step   in   advance enable; when 0, all state holds
//   mem_ready     in   bus completes the current access this cycle
//   insn_refetch  in   DECODE feedback: another fetch word is needed
//   mem_access    in   DECODE feedback: a MEMORY phase is needed
//   mem_addr_in   in   data address, captured in DECODE
//   halt_req      in   EXECUTE feedback: the instruction is a halt
//   jump_taken    in   EXECUTE feedback: the jump condition is true
//   jump_target   in   new ip when jump_taken
//   resume        in   leave HALT
//   state         out  FETCH=0 DECODE=1 MEMORY=2 EXECUTE=3 WRITEBACK=4 HALT=5
//   ip            out  instruction pointer
//   bus_req       out  bus access active (FETCH or MEMORY)
//   bus_addr      out  ip in FETCH, latched data address in MEMORY, else 0
//   wb_en         out  register writeback strobe
//   bus_timeout   out  sticky bus timeout flag, cleared by resume
//   retired_count out  number of completed instructions (wraps)
// -----------------------------------------------------------------------------
module core_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                INSN_BYTES   = 4,
    parameter int                TIMEOUT      = 255,
    parameter int                CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_step,
    input  logic              mem_ready,
    input  logic              insn_refetch,
    input  logic              mem_access,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic              halt_req,
    input  logic              jump_taken,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              resume,
    output logic [2:0]        state,
    output logic [ADDR_W-1:0] ip,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              wb_en,
    output logic              bus_timeout,
    output logic [CNT_W-1:0]  retired_count
);

    // A disabled timeout still needs a one-bit counter to keep widths legal.
    localparam int WAIT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_MEMORY    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   ip_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                timeout_q;
    logic [CNT_W-1:0]    count_q;
    logic                timeout_hit;

    // Last permitted wait cycle of a bus access with ready still low.
    assign timeout_hit = (TIMEOUT > 0) && (wait_q == WAIT_W'(TO_LAST));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else if (enable_step) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)        state_d = S_DECODE;
                else if (timeout_hit) state_d = S_HALT;
            end
            S_DECODE: begin
                if (insn_refetch)     state_d = S_FETCH;
                else if (mem_access)  state_d = S_MEMORY;
                else                  state_d = S_EXECUTE;
            end
            S_MEMORY: begin
                if (mem_ready)        state_d = S_EXECUTE;
                else if (timeout_hit) state_d = S_HALT;
            end
            S_EXECUTE: begin
                if (halt_req)         state_d = S_HALT;
                else                  state_d = S_WRITEBACK;
            end
            S_WRITEBACK:              state_d = S_FETCH;
            S_HALT: begin
                if (resume)           state_d = S_FETCH;
            end
            default:                  state_d = S_FETCH;
        endcase
    end

    // Instruction pointer, data address latch, wait counter, flags, counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ip_q      <= RESET_VECTOR;
            addr_q    <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else if (enable_step) begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ip_q   <= ip_q + ADDR_W'(INSN_BYTES);
                        wait_q <= '0;
                    end else if (timeout_hit) begin
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (!insn_refetch && mem_access) addr_q <= mem_addr_in;
                end
                S_MEMORY: begin
                    if (mem_ready) begin
                        wait_q <= '0;
                    end else if (timeout_hit) begin
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_EXECUTE: begin
                    // A halt leaves ip untouched even when the jump is taken.
                    if (!halt_req && jump_taken) ip_q <= jump_target;
                end
                S_WRITEBACK: begin
                    count_q <= count_q + CNT_W'(1);
                end
                S_HALT: begin
                    if (resume) begin
                        timeout_q <= 1'b0;
                        wait_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        bus_req  = 1'b0;
        bus_addr = '0;
        wb_en    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus_req  = 1'b1;
                bus_addr = ip_q;
            end
            S_MEMORY: begin
                bus_req  = 1'b1;
                bus_addr = addr_q;
            end
            S_WRITEBACK: wb_en = enable_step;
            default: ;
        endcase
    end

    assign state         = state_q;
    assign ip            = ip_q;
    assign bus_timeout   = timeout_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer
//
// Self-checking bench for core_sequencer. A behavioural reference model holds
// the architectural view (phase, ip, data address, wait count, flag, retired
// count) and is advanced by the sequencing rules once per clock. Directed
// scenarios are followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_core_sequencer;

    localparam int AW = 16;
    localparam int CW = 4;
    localparam int TO = 5;
    localparam int IB = 4;
    localparam int unsigned AMASK = (1 << AW) - 1;
    localparam int unsigned CMASK = (1 << CW) - 1;

    localparam int PH_FETCH = 0;
    localparam int PH_DEC   = 1;
    localparam int PH_MEM   = 2;
    localparam int PH_EXE   = 3;
    localparam int PH_WB    = 4;
    localparam int PH_HALT  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_step;
    logic          mem_ready;
    logic          insn_refetch;
    logic          mem_access;
    logic [AW-1:0] mem_addr_in;
    logic          halt_req;
    logic          jump_taken;
    logic [AW-1:0] jump_target;
    logic          resume;
    logic [2:0]    state;
    logic [AW-1:0] ip;
    logic          bus_req;
    logic [AW-1:0] bus_addr;
    logic          wb_en;
    logic          bus_timeout;
    logic [CW-1:0] retired_count;

    core_sequencer #(
        .ADDR_W      (AW),
        .RESET_VECTOR(16'h0000),
        .INSN_BYTES  (IB),
        .TIMEOUT     (TO),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_step  (enable_step),
        .mem_ready    (mem_ready),
        .insn_refetch (insn_refetch),
        .mem_access   (mem_access),
        .mem_addr_in  (mem_addr_in),
        .halt_req     (halt_req),
        .jump_taken   (jump_taken),
        .jump_target  (jump_target),
        .resume       (resume),
        .state        (state),
        .ip           (ip),
        .bus_req      (bus_req),
        .bus_addr     (bus_addr),
        .wb_en        (wb_en),
        .bus_timeout  (bus_timeout),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model
    int          m_ph;
    int unsigned m_ip, m_addr, m_wait, m_cnt;
    bit          m_to;
    int          wb_seen, mem_seen;

    task automatic model_reset();
        m_ph = PH_FETCH; m_ip = 0; m_addr = 0; m_wait = 0; m_to = 0; m_cnt = 0;
    endtask

    // Bus phase shared by FETCH and MEMORY: returns 1 when the access finishes.
    function automatic bit bus_phase();
        if (mem_ready) begin
            m_wait = 0;
            return 1;
        end
        if (TO > 0 && m_wait == TO - 1) begin
            m_ph = PH_HALT;
            m_to = 1;
        end else begin
            m_wait++;
        end
        return 0;
    endfunction

    task automatic model_step();
        if (!enable_step) return;
        if (m_ph == PH_FETCH) begin
            if (bus_phase()) begin
                m_ip = (m_ip + IB) & AMASK;
                m_ph = PH_DEC;
            end
        end else if (m_ph == PH_DEC) begin
            if (insn_refetch) m_ph = PH_FETCH;
            else if (mem_access) begin
                m_addr = mem_addr_in;
                m_ph = PH_MEM;
            end else m_ph = PH_EXE;
        end else if (m_ph == PH_MEM) begin
            if (bus_phase()) m_ph = PH_EXE;
        end else if (m_ph == PH_EXE) begin
            if (halt_req) m_ph = PH_HALT;
            else begin
                if (jump_taken) m_ip = jump_target;
                m_ph = PH_WB;
            end
        end else if (m_ph == PH_WB) begin
            m_cnt = (m_cnt + 1) & CMASK;
            m_ph = PH_FETCH;
        end else if (m_ph == PH_HALT) begin
            if (resume) begin
                m_ph = PH_FETCH;
                m_to = 0;
                m_wait = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        int unsigned exp_addr;
        exp_addr = (m_ph == PH_FETCH) ? m_ip : (m_ph == PH_MEM) ? m_addr : 0;
        check("state", state, m_ph);
        check("ip", ip, m_ip);
        check("bus_req", bus_req, (m_ph == PH_FETCH || m_ph == PH_MEM));
        check("bus_addr", bus_addr, exp_addr);
        check("wb_en", wb_en, (m_ph == PH_WB) && enable_step);
        check("bus_timeout", bus_timeout, m_to);
        check("retired_count", retired_count, m_cnt);
    endtask

    // One clock: compare, tally, advance the model, pass the edge.
    task automatic tick();
        #1;
        compare_outputs();
        if (wb_en) wb_seen++;
        if (bus_req && state == 3'd2 && bus_addr == 16'h0100) mem_seen++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        enable_step = 1; mem_ready = 0; insn_refetch = 0; mem_access = 0;
        mem_addr_in = '0; halt_req = 0; jump_taken = 0; jump_target = '0; resume = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        model_reset();
        #1;
        compare_outputs();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        set_idle();
        rst = 1;
        do_reset();
        check("reset_state", state, 0);
        check("reset_ip", ip, 0);

        // Three plain instructions with an always-ready bus.
        wb_seen = 0;
        mem_ready = 1;
        repeat (12) tick();
        check("t1_retired", retired_count, 3);
        check("t1_ip", ip, 16'h000C);
        check("t1_wb_cycles", wb_seen, 3);
        check("t1_state", state, PH_FETCH);

        // Memory instruction with four wait states.
        tick();                                   // FETCH -> DECODE
        mem_access = 1; mem_addr_in = 16'h0100; mem_ready = 0;
        tick();                                   // DECODE -> MEMORY
        mem_access = 0; mem_addr_in = 16'h0BAD;
        mem_seen = 0;
        repeat (4) tick();
        mem_ready = 1;
        tick();                                   // MEMORY -> EXECUTE
        check("t2_mem_cycles", mem_seen, 5);
        check("t2_state", state, PH_EXE);
        check("t2_timeout", bus_timeout, 0);
        mem_ready = 0;
        repeat (2) tick();                        // EXECUTE, WRITEBACK

        // Taken jump.
        mem_ready = 1; tick();
        mem_ready = 0; tick();
        jump_taken = 1; jump_target = 16'h0040; tick();
        jump_taken = 0; tick();
        check("t3_bus_addr", bus_addr, 16'h0040);
        check("t3_bus_req", bus_req, 1);

        // Halt wins over a taken jump; then resume.
        mem_ready = 1; tick();
        mem_ready = 0; tick();
        halt_req = 1; jump_taken = 1; jump_target = 16'h0080; tick();
        halt_req = 0; jump_taken = 0;
        check("t4_state", state, PH_HALT);
        check("t4_ip", ip, 16'h0044);
        check("t4_retired", retired_count, 5);
        check("t4_bus_req", bus_req, 0);
        mem_ready = 1; repeat (2) tick();         // ready ignored in HALT
        mem_ready = 0; resume = 1; tick();
        resume = 0;
        check("t4_resumed", state, PH_FETCH);

        // Bus timeout in FETCH.
        repeat (4) tick();
        check("t5_pre_state", state, PH_FETCH);
        tick();
        check("t5_state", state, PH_HALT);
        check("t5_timeout", bus_timeout, 1);
        check("t5_ip", ip, 16'h0044);
        resume = 1; tick(); resume = 0;
        check("t5_resume_state", state, PH_FETCH);
        check("t5_resume_flag", bus_timeout, 0);

        // Ready on the last permitted wait cycle completes normally.
        repeat (4) tick();
        mem_ready = 1; tick(); mem_ready = 0;
        check("t5b_state", state, PH_DEC);
        check("t5b_timeout", bus_timeout, 0);
        check("t5b_ip", ip, 16'h0048);
        repeat (3) tick();                        // DECODE, EXECUTE, WRITEBACK

        // Step enable toggling; ready pulses while disabled.
        for (int i = 0; i < 16; i++) begin
            enable_step = (i % 2 == 0);
            mem_ready = enable_step ? 1'b1 : 1'($urandom);
            tick();
        end
        enable_step = 1; mem_ready = 0;
        check("t6_retired", retired_count, 8);
        check("t6_ip", ip, 16'h0050);

        // Reset in the middle of a MEMORY wait.
        mem_ready = 1; tick();
        mem_access = 1; mem_addr_in = 16'h0200; mem_ready = 0; tick();
        mem_access = 0; repeat (2) tick();
        check("t7_pre_state", state, PH_MEM);
        #2;
        rst = 0;
        model_reset();
        #1;
        check("t7_state", state, PH_FETCH);
        check("t7_ip", ip, 16'h0000);
        check("t7_retired", retired_count, 0);
        check("t7_wb_en", wb_en, 0);
        @(posedge clk);
        #1;
        rst = 1;

        // ip wraps around the address space.
        mem_ready = 1; tick();
        mem_ready = 0; tick();
        jump_taken = 1; jump_target = 16'hFFFC; tick();
        jump_taken = 0; tick();
        check("t8_ip_before", ip, 16'hFFFC);
        mem_ready = 1; tick(); mem_ready = 0;
        check("t8_ip_wrap", ip, 16'h0000);

        // Randomized run.
        for (int i = 0; i < 4000; i++) begin
            enable_step  = ($urandom_range(3) != 0);
            mem_ready    = ($urandom_range(2) == 0);
            insn_refetch = ($urandom_range(4) == 0);
            mem_access   = 1'($urandom);
            mem_addr_in  = AW'($urandom);
            halt_req     = ($urandom_range(7) == 0);
            jump_taken   = 1'($urandom);
            jump_target  = AW'($urandom);
            resume       = ($urandom_range(3) == 0);
            if ($urandom_range(499) == 0) do_reset();
            else tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
